// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for the 9-bit accumulator ISA.
// Walks FETCH -> EXEC (-> MEM_WAIT for loads), raises exactly one cycle of
// write/branch strobes per instruction, and keeps a sticky illegal-opcode
// flag and a saturating retired-instruction counter.
module ctrl_seq #(
    parameter int IW      = 9,
    parameter int OPW     = 4,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [IW-1:0]    Instruction,
    input  logic             to_jump,
    output logic             Branch,
    output logic             PcAdvance,
    output logic             RegWrEn,
    output logic             AccWrEn,
    output logic             MemWrEn,
    output logic             LoadInst,
    output logic             halt,
    output logic             Busy,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM_WAIT,
        S_HALTED
    } state_t;

    localparam logic [OPW-1:0] OP_LSL  = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_LSR  = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_ORR  = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_EOR  = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_TAKE = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_MOV  = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_LDR  = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_STR  = OPW'(4'h9);
    localparam logic [OPW-1:0] OP_CMP  = OPW'(4'hA);
    localparam logic [OPW-1:0] OP_B    = OPW'(4'hB);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'hC);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(4'hD);
    localparam logic [OPW-1:0] OP_HALT = OPW'(4'hE);
    localparam logic [OPW-1:0] OP_ILL  = OPW'(4'hF);

    // The first MEM_WAIT cycle already holds MEM_LAT-1; the cycle that sees 0 completes.
    localparam logic [3:0] LAT_INIT = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);

    state_t           state;
    state_t           state_next;
    logic [3:0]       wait_cnt;
    logic             illegal_q;
    logic [CNT_W-1:0] inst_count_q;

    logic             is_op;
    logic [OPW-1:0]   opcode;
    logic             exec_halt;
    logic             exec_ldr_wait;
    logic             exec_illegal;
    logic             wait_done;
    logic             retire;
    logic             unused_operand;

    assign is_op          = Instruction[IW-1];
    assign opcode         = Instruction[IW-2 -: OPW];
    // Operand bits are consumed by the datapath, not by the sequencer.
    assign unused_operand = ^Instruction;

    assign exec_halt     = (state == S_EXEC) && is_op && (opcode == OP_HALT);
    assign exec_ldr_wait = (state == S_EXEC) && is_op && (opcode == OP_LDR) && (MEM_LAT != 0);
    assign exec_illegal  = (state == S_EXEC) && is_op && (opcode == OP_ILL);
    assign wait_done     = (wait_cnt == 4'd0);
    // Every retirement carries exactly one of Branch / PcAdvance.
    assign retire        = Branch | PcAdvance;

    assign IllegalOp = illegal_q;
    assign InstCount = inst_count_q;

    // State register plus load-wait counter, sticky illegal flag and retire counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            wait_cnt     <= 4'd0;
            illegal_q    <= 1'b0;
            inst_count_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state <= state_next;
            if (exec_ldr_wait)
                wait_cnt <= LAT_INIT;
            else if ((state == S_MEM_WAIT) && !wait_done)
                wait_cnt <= wait_cnt - 4'd1;
            if (exec_illegal)
                illegal_q <= 1'b1;
            if (retire && (inst_count_q != {CNT_W{1'b1}}))
                inst_count_q <= inst_count_q + CNT_W'(1);
        end
    end

    // Next-state selection.
    always_comb begin
        // NOTE: default first so no path through this block leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:     if (Start) state_next = S_FETCH;
            S_FETCH:    state_next = S_EXEC;
            S_EXEC: begin
                if (exec_halt)
                    state_next = S_HALTED;
                else if (exec_ldr_wait)
                    state_next = S_MEM_WAIT;
                else
                    state_next = S_FETCH;
            end
            S_MEM_WAIT: if (wait_done) state_next = S_FETCH;
            S_HALTED:   if (Start) state_next = S_FETCH;
            default:    state_next = S_IDLE;
        endcase
    end

    // Strobe decode from state, with the instruction looked at only in EXEC.
    always_comb begin
        Branch    = 1'b0;
        PcAdvance = 1'b0;
        RegWrEn   = 1'b0;
        AccWrEn   = 1'b0;
        MemWrEn   = 1'b0;
        LoadInst  = 1'b0;
        halt      = (state == S_HALTED);
        Busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM_WAIT);
        case (state)
            S_EXEC: begin
                if (!is_op) begin
                    AccWrEn   = 1'b1;
                    PcAdvance = 1'b1;
                end else begin
                    case (opcode)
                        OP_LSL, OP_LSR, OP_ADD, OP_AND, OP_ORR, OP_EOR, OP_TAKE, OP_CMP: begin
                            AccWrEn   = 1'b1;
                            PcAdvance = 1'b1;
                        end
                        OP_MOV: begin
                            RegWrEn   = 1'b1;
                            PcAdvance = 1'b1;
                        end
                        OP_STR: begin
                            MemWrEn   = 1'b1;
                            PcAdvance = 1'b1;
                        end
                        OP_LDR: begin
                            LoadInst = 1'b1;
                            if (MEM_LAT == 0) begin
                                AccWrEn   = 1'b1;
                                PcAdvance = 1'b1;
                            end
                        end
                        OP_B:    Branch = 1'b1;
                        OP_BEQ: begin
                            Branch    = to_jump;
                            PcAdvance = !to_jump;
                        end
                        OP_BNE: begin
                            Branch    = !to_jump;
                            PcAdvance = to_jump;
                        end
                        OP_HALT: ;
                        // Undefined opcodes retire as a nop.
                        default: PcAdvance = 1'b1;
                    endcase
                end
            end
            S_MEM_WAIT: begin
                LoadInst = 1'b1;
                if (wait_done) begin
                    AccWrEn   = 1'b1;
                    PcAdvance = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
